multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Sequencing controller for the multi-cycle RV32I core (RV32I = 32-bit base integer RISC-V).
//  Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Drives select lines for the immediate generator, ALU operand muxes, register file, PC and the shared
//  instruction/data memory port. Decodes opcode from the datapath IR (IR = instruction register), waits on memory handshake.
// PARAMETERS
//  MAX_WAIT  15  cycles FETCH/MEM may wait for mem_ready before bus timeout (1..255)
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  reset        in   1  synchronous, active-high reset
//  opcode       in   7  IR[6:0], stable from cycle after ir_write
//  branch_taken in   1  datapath compare result (funct3-qualified), valid in EXEC
//  mem_ready    in   1  memory completes current request this cycle
//  mem_req      out  1  memory request (held until mem_ready)
//  mem_we       out  1  write strobe, qualifies mem_req
//  mem_src      out  1  0=address PC, 1=address ALU result
//  ir_write     out  1  latch memory read data into IR
//  imm_type     out  3  0=I 1=S 2=B 3=U 4=J 7=none
//  alu_src_a    out  2  0=rs1 1=PC 2=zero
//  alu_src_b    out  1  0=rs2 1=immediate
//  alu_op       out  2  0=add 1=funct decode 2=compare
//  reg_write    out  1  register file write enable
//  wb_sel       out  2  0=ALU 1=memory data 2=PC+4
//  pc_write     out  1  PC update enable
//  pc_src       out  2  0=PC+4 1=PC+imm 2=(rs1+imm)&~1
//  state        out  3  current state, for debug
//  halted       out  1  sticky, controller in HALT
// BEHAVIOUR
//  - States: RESET=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6.
//  - Outputs: combinational from registered state and opcode; all 0 in RESET/HALT except halted.
//  - Reset: state=RESET, wait counter=0, halted=0; all outputs 0. RESET->FETCH next cycle unconditionally.
//  - Reset mid-operation: aborts immediately; outstanding request is dropped (mem_req=0 next cycle).
//  - Data-path selects (imm_type, alu_*, wb_sel) are driven from opcode in DECODE, EXEC, MEM and WB; 0 elsewhere.
//  - FETCH: mem_req=1, mem_src=0.
//    mem_ready -> ir_write=1 in same cycle -> DECODE.
//  - DECODE: 1 cycle; imm_type valid, register file read.
//    Legal opcode -> EXEC.
//    Illegal opcode -> see CONFIGURATION.
//  - Legal opcodes: 0000011 LOAD, 0010011 OP-IMM, 0010111 AUIPC, 0100011 STORE, 0110011 OP,
//    0110111 LUI, 1100011 BRANCH, 1100111 JALR, 1101111 JAL.
//  - EXEC selects per opcode:
//    OP: a=0 b=0 op=1
//    OP-IMM: a=0 b=1 op=1
//    LOAD/STORE/JALR: a=0 b=1 op=0
//    AUIPC/JAL: a=1 b=1 op=0
//    LUI: a=2 b=1 op=0
//    BRANCH: a=0 b=0 op=2
//  - EXEC transitions:
//    BRANCH: pc_write=1, pc_src = branch_taken ? 1 : 0 -> FETCH
//    LOAD/STORE -> MEM
//    others -> WB
//  - MEM: mem_req=1, mem_src=1, mem_we = STORE.
//    mem_ready & STORE -> pc_write=1, pc_src=0 -> FETCH.
//    mem_ready & LOAD -> WB.
//  - WB: reg_write=1, pc_write=1 -> FETCH.
//    wb_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
//    pc_src: 1 for JAL, 2 for JALR, else 0.
//  - Latency in cycles, excluding memory waits:
//    OP/OP-IMM/LUI/AUIPC/JAL/JALR 4, LOAD 5, STORE 4, BRANCH 3.
//  - Wait counter: counts consecutive FETCH/MEM cycles with mem_ready=0.
//    Clears on mem_ready or state exit.
//    Counter reaches MAX_WAIT with mem_ready still 0 -> HALT next cycle.
//    mem_ready on that same cycle wins; no HALT.
//  - HALT: absorbing, halted=1, leaves only via reset.
//  - pc_write and reg_write are never both asserted outside WB; no simultaneous write is possible in other states.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    - illegal opcode in DECODE -> HALT, halted=1 next cycle, no register or PC write.
//  ILLEGAL_TRAP_EN undefined:
//    - illegal opcode is treated as NOP: DECODE -> WB with reg_write=0, pc_write=1, pc_src=0 -> FETCH.
// TESTING
//  1 reset held 3 cycles, release, mem_ready=1 -> state 0,0,0 then 1, mem_req=1, all other outputs 0
//  2 opcode 0110011, mem_ready=1 -> states 1,2,3,5,1; WB: reg_write=1, wb_sel=0, pc_src=0
//  3 opcode 0000011, mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_we=0; WB wb_sel=1
//  4 opcode 1100011, branch_taken=1 then 0 -> EXEC pc_write=1 with pc_src=1, then pc_src=0; imm_type=2
//  5 MAX_WAIT=15, mem_ready=0 in FETCH -> HALT after 16 FETCH cycles, halted=1; reset -> state=0
//  6 opcode 0000000 -> with ILLEGAL_TRAP_EN halted=1; without it: WB pc_write=1, reg_write=0, then FETCH

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Shared instruction/data memory port between the multi-cycle controller and the memory.
// The controller is the master; it holds mem_req until the memory answers with mem_ready.
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB with bus timeout.
// Define ILLEGAL_TRAP_EN to halt on an illegal opcode; otherwise illegal opcodes retire as NOPs.
module multicycle_control_fsm #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [6:0]                      opcode,
  input  logic                            branch_taken,
  multicycle_control_fsm_if.master        mem,
  output logic                            ir_write,
  output logic [2:0]                      imm_type,
  output logic [1:0]                      alu_src_a,
  output logic                            alu_src_b,
  output logic [1:0]                      alu_op,
  output logic                            reg_write,
  output logic [1:0]                      wb_sel,
  output logic                            pc_write,
  output logic [1:0]                      pc_src,
  output logic [2:0]                      state,
  output logic                            halted
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [7:0] MaxWait  = 8'(MAX_WAIT);

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic       legal;
  logic [2:0] sel_imm;
  logic [1:0] sel_a;
  logic       sel_b;
  logic [1:0] sel_op;
  logic [1:0] sel_wb;
  logic       sel_en;

  // Per-opcode datapath selects; only exported while an instruction is in flight.
  always_comb begin
    legal   = 1'b1;
    sel_imm = 3'd7;
    sel_a   = 2'd0;
    sel_b   = 1'b0;
    sel_op  = 2'd0;
    sel_wb  = 2'd0;
    case (opcode)
      OpLoad:   begin sel_imm = 3'd0; sel_b = 1'b1; sel_wb = 2'd1; end
      OpOpImm:  begin sel_imm = 3'd0; sel_b = 1'b1; sel_op = 2'd1; end
      OpAuipc:  begin sel_imm = 3'd3; sel_a = 2'd1; sel_b = 1'b1; end
      OpStore:  begin sel_imm = 3'd1; sel_b = 1'b1; end
      OpOp:     sel_op = 2'd1;
      OpLui:    begin sel_imm = 3'd3; sel_a = 2'd2; sel_b = 1'b1; end
      OpBranch: begin sel_imm = 3'd2; sel_op = 2'd2; end
      OpJalr:   begin sel_imm = 3'd0; sel_b = 1'b1; sel_wb = 2'd2; end
      OpJal:    begin sel_imm = 3'd4; sel_a = 2'd1; sel_b = 1'b1; sel_wb = 2'd2; end
      default:  legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StReset;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    sel_en       = 1'b0;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_src  = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    halted       = 1'b0;
    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        sel_en = 1'b1;
        if (legal) begin
          state_d = StExec;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = StHalt;
`else
          state_d = StWb;
`endif
        end
      end
      StExec: begin
        sel_en = 1'b1;
        if (opcode == OpBranch) begin
          pc_write = 1'b1;
          pc_src   = {1'b0, branch_taken};
          state_d  = StFetch;
        end else if (opcode == OpLoad || opcode == OpStore) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        sel_en      = 1'b1;
        mem.mem_req = 1'b1;
        mem.mem_src = 1'b1;
        mem.mem_we  = (opcode == OpStore);
        if (mem.mem_ready) begin
          if (opcode == OpStore) begin
            pc_write = 1'b1;
            state_d  = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        sel_en    = 1'b1;
        reg_write = legal;  // illegal opcodes only reach here as a NOP
        pc_write  = 1'b1;
        if (opcode == OpJal) pc_src = 2'd1;
        else if (opcode == OpJalr) pc_src = 2'd2;
        state_d = StFetch;
      end
      StHalt: halted = 1'b1;
      default: state_d = StReset;
    endcase

    // Bus timeout: a ready on the final allowed cycle still completes normally.
    if ((state_q == StFetch || state_q == StMem) && !mem.mem_ready) begin
      if (wait_q == MaxWait) state_d = StHalt;
      else wait_d = wait_q + 8'd1;
    end
  end

  assign imm_type  = sel_en ? sel_imm : 3'd0;
  assign alu_src_a = sel_en ? sel_a   : 2'd0;
  assign alu_src_b = sel_en ? sel_b   : 1'b0;
  assign alu_op    = sel_en ? sel_op  : 2'd0;
  assign wb_sel    = sel_en ? sel_wb  : 2'd0;
  assign state     = state_q;

endmodule
